// File: rtl/s2p_conv_1x4.sv
// Serial-to-nibble converter: 1-bit ready/valid stream in, 4-bit nibbles with sop tag out.
// Define S2P_FIFO_EN for a FIFO_DEPTH-entry output FIFO; the default build uses a single output register.
module s2p_conv_1x4 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       idat,
  input  logic       ival,
  input  logic       isop,
  output logic       oreq,
  input  logic       ireq,
  output logic [3:0] odat,
  output logic       oval,
  output logic       osop,
  output logic       oerr
);

  typedef struct packed {
    logic       sop;
    logic [3:0] dat;
  } ent_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("s2p_conv_1x4: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [2:0] sh_q, sh_d;
  logic [1:0] cnt_q, cnt_d;
  logic       sop_q, sop_d;
  logic       oerr_q, oerr_d;
  logic       acc, push, pop, full;
  ent_t       push_ent;

  assign acc  = ival & oreq;
  assign pop  = oval & ireq;
  // Only the completing bit waits for room; bits 0..2 keep flowing while the output is full.
  assign oreq = ~(full & (cnt_q == 2'd3));

  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    oerr_d   = 1'b0;
    push     = 1'b0;
    push_ent = ent_t'({sop_q, sh_q, idat});
    if (acc) begin
      sh_d = {sh_q[1:0], idat};
      if (isop) begin
        cnt_d  = 2'd1;
        sop_d  = 1'b1;
        oerr_d = (cnt_q != 2'd0);
      end else begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          push  = 1'b1;
          sop_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      sop_q  <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      sop_q  <= sop_d;
      oerr_q <= oerr_d;
    end
  end

  assign oerr = oerr_q;

`ifdef S2P_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  ent_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   occ_q;

  assign full = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign oval = (occ_q != '0);

  always_ff @(posedge iclk) begin
    if (push) mem_q[wp_q] <= push_ent;
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      if (push && !pop)      occ_q <= occ_q + (AW+1)'(1);
      else if (pop && !push) occ_q <= occ_q - (AW+1)'(1);
    end
  end

  assign odat = oval ? mem_q[rp_q].dat : 4'h0;
  assign osop = oval & mem_q[rp_q].sop;
`else
  ent_t ent_q;
  logic val_q;

  assign full = val_q;
  assign oval = val_q;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ent_q <= '0;
      val_q <= 1'b0;
    end else if (push) begin
      ent_q <= push_ent;
      val_q <= 1'b1;
    end else if (pop) begin
      val_q <= 1'b0;
    end
  end

  assign odat = val_q ? ent_q.dat : 4'h0;
  assign osop = val_q & ent_q.sop;
`endif

endmodule

// File: tb/tb_s2p_conv_1x4.sv
// Bench for s2p_conv_1x4: directed vector table, corner-case sequences, random traffic vs a queue model.
module tb_s2p_conv_1x4;

`ifdef S2P_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       idat = 1'b0, ival = 1'b0, isop = 1'b0, ireq = 1'b0;
  logic       oreq, oval, osop, oerr;
  logic [3:0] odat;

  s2p_conv_1x4 #(.FIFO_DEPTH(4)) dut (
    .iclk(iclk), .irst(irst), .idat(idat), .ival(ival), .isop(isop),
    .oreq(oreq), .ireq(ireq), .odat(odat), .oval(oval), .osop(osop), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;
  int cycn  = 0;

  // Reference model: queue of expected {sop,nibble}, plus the partial nibble being collected.
  logic [4:0] q[$];
  int         nb = 0;
  int         pv = 0;
  logic       psop = 1'b0;
  logic       err_exp = 1'b0;
  logic       last_acc = 1'b0;
  logic [4:0] obs[$];
  int         obs_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycn);
    end
  endtask

  task automatic model_clear();
    q.delete();
    nb = 0; pv = 0; psop = 1'b0; err_exp = 1'b0;
  endtask

  // Apply inputs for one cycle, check outputs against the model, advance the model across the edge.
  task automatic cyc(input logic v, input logic d, input logic s, input logic r);
    logic m_oval, m_oreq, acc, pop, e;
    ival = v; idat = d; isop = s; ireq = r;
    #1;
    m_oval = (q.size() > 0);
    m_oreq = !((q.size() >= DEPTH) && (nb == 3));
    chk("oval", oval, m_oval);
    chk("oreq", oreq, m_oreq);
    chk("oerr", oerr, err_exp);
    if (m_oval) begin
      chk("odat", odat, q[0][3:0]);
      chk("osop", osop, q[0][4]);
    end
    if (oval && r) begin
      obs.push_back({osop, odat});
      obs_cyc.push_back(cycn);
    end
    acc = v && m_oreq;
    pop = m_oval && r;
    last_acc = acc;
    e = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (s) begin
        e = (nb != 0);
        nb = 1; pv = d; psop = 1'b1;
      end else begin
        pv = pv * 2 + d;
        nb++;
        if (nb == 4) begin
          q.push_back({psop, 4'(pv)});
          psop = 1'b0; nb = 0; pv = 0;
        end
      end
    end
    err_exp = e;
    @(posedge iclk); #1;
    cycn++;
  endtask

  task automatic send_bit(input logic d, input logic s, input logic r);
    int k;
    k = 0;
    do begin
      cyc(1'b1, d, s, r);
      k++;
    end while (!last_acc && k < 64);
    if (!last_acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: bit never accepted after %0d cycles", k);
    end
  endtask

  task automatic do_reset();
    irst = 1'b0; ival = 1'b0; isop = 1'b0; idat = 1'b0; ireq = 1'b0;
    #1;
    chk("rst_oval", oval, 1'b0);
    chk("rst_oreq", oreq, 1'b1);
    chk("rst_osop", osop, 1'b0);
    chk("rst_oerr", oerr, 1'b0);
    chk("rst_odat", odat, 4'h0);
    @(posedge iclk); #1;
    irst = 1'b1;
    model_clear();
  endtask

  typedef struct packed {
    logic       v, d, s, r;
    logic       eov;
    logic [3:0] eod;
    logic       eos, eer;
  } vec_t;

  vec_t tbl[21];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bits;
    logic [3:0]  nib;
    int          n;

    // {v d s r, exp oval, exp odat, exp osop, exp oerr}
    tbl[0]  = {4'b1111, 1'b0, 4'h0, 2'b00};
    tbl[1]  = {4'b1001, 1'b0, 4'h0, 2'b00};
    tbl[2]  = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[3]  = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[4]  = {4'b0001, 1'b1, 4'hB, 2'b10};
    tbl[5]  = {4'b1001, 1'b0, 4'h0, 2'b00};
    tbl[6]  = {4'b0001, 1'b0, 4'h0, 2'b00};
    tbl[7]  = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[8]  = {4'b0001, 1'b0, 4'h0, 2'b00};
    tbl[9]  = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[10] = {4'b0001, 1'b0, 4'h0, 2'b00};
    tbl[11] = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[12] = {4'b0001, 1'b1, 4'h7, 2'b00};
    tbl[13] = {4'b1111, 1'b0, 4'h0, 2'b00};
    tbl[14] = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[15] = {4'b1111, 1'b0, 4'h0, 2'b00};
    tbl[16] = {4'b1001, 1'b0, 4'h0, 2'b01};
    tbl[17] = {4'b1001, 1'b0, 4'h0, 2'b00};
    tbl[18] = {4'b1101, 1'b0, 4'h0, 2'b00};
    tbl[19] = {4'b0001, 1'b1, 4'h9, 2'b10};
    tbl[20] = {4'b0001, 1'b0, 4'h0, 2'b00};

    #2;
    do_reset();

    // Directed table: sop nibble 0xB, toggling ival nibble 0x7, restart with error then 0x9.
    for (int i = 0; i < 21; i++) begin
      #1;
      chk("tbl_oval", oval, tbl[i].eov);
      chk("tbl_oerr", oerr, tbl[i].eer);
      if (tbl[i].eov) begin
        chk("tbl_odat", odat, tbl[i].eod);
        chk("tbl_osop", osop, tbl[i].eos);
      end
      cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
    end

    // Continuous 8-bit packet 1010_0110.
    obs.delete(); obs_cyc.delete();
    bits = 12'b1010_0110_0000;
    for (int i = 0; i < 8; i++) send_bit(bits[11-i], (i == 0), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pkt8_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("pkt8_first", obs[0], 5'h1A);
      chk("pkt8_second", obs[1], 5'h06);
      chk("pkt8_spacing", obs_cyc[1] - obs_cyc[0], 4);
    end

    // Backpressure: stream with ireq=0 until the output stage is full and 3 bits are pending.
    obs.delete(); obs_cyc.delete();
    bits = 12'($urandom);
    n = (DEPTH > 1) ? 12 : 7;
    for (int i = 0; i < n; i++) send_bit(bits[11-i], (i == 0), 1'b0);
    #1;
`ifdef S2P_FIFO_EN
    chk("stall_oreq", oreq, 1'b1);
`else
    chk("stall_oreq", oreq, 1'b0);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = n; i < 12; i++) send_bit(bits[11-i], 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        nib = bits[11-4*k -: 4];
        chk("stall_order", obs[k], {(k == 0), nib});
      end
    end

    // Reset with stored nibbles and a partial nibble in flight.
    n = (DEPTH > 1) ? 11 : 7;
    for (int i = 0; i < n; i++) send_bit(1'($urandom), (i == 0), 1'b0);
    do_reset();
    obs.delete(); obs_cyc.delete();
    bits = 12'b1100_0000_0000;
    for (int i = 0; i < 4; i++) send_bit(bits[11-i], 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("postrst_count", obs.size(), 1);
    if (obs.size() >= 1) chk("postrst_nib", obs[0], 5'h0C);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", oval, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2p_conv_1x4.md
S2P_CONV_1X4 -- requirements
Module: s2p_conv_1x4

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output FIFO entries when S2P_FIFO_EN is defined; power of 2, >= 2; ignored otherwise.
REQ-002 iclk  input  1  clock; all state on rising edge.
REQ-003 irst  input  1  reset, asynchronous, active-low.
REQ-004 idat  input  1  serial data bit.
REQ-005 ival  input  1  idat valid.
REQ-006 isop  input  1  marks the first bit of a packet; qualified by ival.
REQ-007 oreq  output 1  ready to upstream; a bit is accepted on an edge where ival=1 and oreq=1.
REQ-008 ireq  input  1  downstream ready; a nibble is transferred on an edge where oval=1 and ireq=1.
REQ-009 odat  output 4  assembled nibble; first received bit in odat[3], last in odat[0].
REQ-010 oval  output 1  odat/osop valid.
REQ-011 osop  output 1  nibble holds the first four bits of a packet.
REQ-012 oerr  output 1  one-cycle pulse: packet restart discarded a partial nibble.

Function
REQ-013 Keep a 3-bit shift register sh and a 2-bit bit counter cnt (0..3); accepted bit: sh <= {sh[1:0], idat}, cnt <= cnt+1 (wraps 3->0).
REQ-014 With ival=0 or oreq=0, sh and cnt hold; no timeout, no clearing of partial nibbles.
REQ-015 Accepted bit with cnt=3 completes nibble {sh[2:0], idat} and pushes it with its sop tag into the output stage on the same edge.
REQ-016 Latency: oval=1 and odat valid in the cycle after the edge accepting the 4th bit.
REQ-017 Accepted bit with isop=1: treated as bit 0 of a new nibble; cnt <= 1, sop tag set for that nibble.
REQ-018 Accepted isop=1 when cnt!=0: partial bits discarded, never output, oerr=1 for the next cycle only.
REQ-019 Sop tag is cleared when its nibble is pushed; later nibbles carry osop=0 until the next isop.
REQ-020 oreq = NOT(output stage full AND cnt=3); driven from registered state only, no combinational path from ireq or ival.
REQ-021 Bits 0..2 of a nibble are accepted while the output stage is full; only the completing bit is stalled.
REQ-022 Push and pop on the same edge: occupancy unchanged, order preserved.
REQ-023 Pop on the only entry with no push: oval=0 the next cycle.
REQ-024 odat, osop hold stable while oval=1 and ireq=0.
REQ-025 Output stage is strict FIFO order; no entry lost or duplicated.
REQ-026 Continuous ival=1, ireq=1: one nibble every 4 cycles, oreq stays 1.

Reset
REQ-027 irst=0 asynchronously clears sh, cnt, sop tag, output stage occupancy; oval=0, osop=0, oerr=0, odat=4'h0, oreq=1.
REQ-028 Reset mid-nibble or with stored nibbles discards all of them; first accepted bit after release is bit 0 of a nibble.
REQ-029 Reset deassertion needs no extra idle cycles; input may be accepted on the first edge after release.

Configuration
REQ-030 Macro S2P_FIFO_EN defined: output stage is a FIFO_DEPTH-entry FIFO of {sop, nibble}; full when occupancy = FIFO_DEPTH.
REQ-031 S2P_FIFO_EN undefined: output stage is a single register; full when oval=1; all other requirements unchanged.

Verification
REQ-032 Reset, then isop=1 with bits 1,0,1,1 on 4 consecutive edges, ireq=1 -> next cycle odat=4'hB, osop=1, oval=1 for one cycle.
REQ-033 Packet 8 bits 1010_0110 continuous, ireq=1 -> nibbles 4'hA (osop=1) then 4'h6 (osop=0), 4 cycles apart.
REQ-034 ireq=0, 12 bits streamed, no FIFO build -> after first nibble oreq=0 at cnt=3; raise ireq -> 4'h? order kept, no loss; FIFO build (depth 4) -> 3 nibbles stored, oreq stays 1.
REQ-035 isop after 2 bits (1,1) then isop+1,0,0,1 -> oerr=1 one cycle, only output 4'h9 with osop=1.
REQ-036 ival toggling 1/0 every cycle with bits 0,1,1,1 -> one nibble 4'h7, oval one cycle after 4th accepted bit.
REQ-037 irst=0 for one cycle after 3 bits and with 2 nibbles stored -> oval=0, oreq=1; next 4 bits 1,1,0,0 -> 4'hC.
